// File: rtl/mdu_iter.sv
// ============================================================================
// Module   : mdu_iter
// Purpose  : Iterative unsigned multiply (shift-add) / divide (restoring) unit,
//            one radix-2 step per clock.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mdu_iter #(
  parameter int         WIDTH   = 32,
  parameter logic [4:0] OP_MULT = 5'b10000,
  parameter logic [4:0] OP_DIV  = 5'b10001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [4:0]       aluop_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r1_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             uf_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             uf_q, uf_d;

  logic             accept_mul, accept_div, accept_dz;
  logic             last_step, flush;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;

  assign accept_mul = start_i && !abort_i && (aluop_i == OP_MULT);
  assign accept_div = start_i && !abort_i && (aluop_i == OP_DIV) && (op2_i != '0);
  assign accept_dz  = start_i && !abort_i && (aluop_i == OP_DIV) && (op2_i == '0);
  assign last_step  = (cnt_q == CNT_W'(1));
  assign flush      = abort_i && (state_q != S_IDLE);

  // Multiply: acc_lo holds the remaining multiplier bits and fills with product bits
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_mul)      state_d = S_MUL;
        else if (accept_div) state_d = S_DIV;
        else if (accept_dz)  state_d = S_DONE;
      end
      S_MUL, S_DIV: begin
        if (abort_i)        state_d = S_IDLE;
        else if (last_step) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    uf_d     = uf_q;
    case (state_q)
      S_IDLE: begin
        if (accept_mul) begin
          cnt_d    = CNT_W'(WIDTH);
          acc_hi_d = '0;
          acc_lo_d = op2_i;
          opb_d    = op1_i;
          uf_d     = 1'b0;
        end else if (accept_div) begin
          cnt_d    = CNT_W'(WIDTH);
          acc_hi_d = '0;
          acc_lo_d = op1_i;
          opb_d    = op2_i;
          uf_d     = 1'b0;
        end else if (accept_dz) begin
          cnt_d    = '0;
          acc_hi_d = op1_i;
          acc_lo_d = '1;
          uf_d     = 1'b1;
        end
      end
      S_MUL: begin
        cnt_d    = cnt_q - CNT_W'(1);
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        uf_d     = last_step && (mul_hi != '0);
      end
      S_DIV: begin
        cnt_d    = cnt_q - CNT_W'(1);
        acc_hi_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
        uf_d     = 1'b0;
      end
      default: ;
    endcase
    if (flush) begin
      cnt_d    = '0;
      acc_hi_d = '0;
      acc_lo_d = '0;
      opb_d    = '0;
      uf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      uf_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      uf_q     <= uf_d;
    end
  end

  assign r1_o = acc_lo_q;
  assign hi_o = acc_hi_q;
  assign uf_o = uf_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
// Module   : tb_mdu_iter
// Purpose  : Scoreboard bench for mdu_iter with directed and random operations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mdu_iter;

  localparam int         W    = 32;
  localparam logic [4:0] MULT = 5'b10000;
  localparam logic [4:0] DIV  = 5'b10001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [4:0]   aluop = '0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         busy, done, uf;
  logic [W-1:0] r1, hi;

  mdu_iter #(.WIDTH(W), .OP_MULT(MULT), .OP_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .aluop_i (aluop),
    .op1_i   (op1),
    .op2_i   (op2),
    .abort_i (abort),
    .busy_o  (busy),
    .done_o  (done),
    .r1_o    (r1),
    .hi_o    (hi),
    .uf_o    (uf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] hi;
    logic         uf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on wide integers
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acc_cyc);
    exp_t         e;
    logic [2*W-1:0] p;
    if (op == MULT) begin
      p     = (2*W)'(a) * (2*W)'(b);
      e.r1  = p[W-1:0];
      e.hi  = p[2*W-1:W];
      e.uf  = (p[2*W-1:W] != '0);
      e.due = acc_cyc + 1 + W;
    end else if (b != '0) begin
      e.r1  = a / b;
      e.hi  = a % b;
      e.uf  = 1'b0;
      e.due = acc_cyc + 1 + W;
    end else begin
      e.r1  = '1;
      e.hi  = a;
      e.uf  = 1'b1;
      e.due = acc_cyc + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("r1", 64'(r1), 64'(e.r1));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("uf", 64'(uf), 64'(e.uf));
        chk("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    int acc;
    @(negedge clk);
    while (busy && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: got busy=1 expected 0 within 300 cycles");
    end
    start = 1'b1;
    aluop = op;
    op1   = a;
    op2   = b;
    @(posedge clk);
    acc = cyc;
    if (op == MULT || op == DIV) sb.push_back(model(op, a, b, acc));
    @(negedge clk);
    start = 1'b0;
    aluop = 5'($urandom);
    op1   = $urandom;
    op2   = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    v = $urandom;
    if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, W - 1);
    return v;
  endfunction

  initial begin
    exp_t         dropped;
    logic [W-1:0] a, b;
    logic [4:0]   op;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_r1", 64'(r1), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_uf", 64'(uf), 64'd0);
    rst_n = 1'b1;

    issue(MULT, 32'd7, 32'd6);
    drain();
    issue(MULT, 32'hFFFF_FFFF, 32'd2);
    drain();
    issue(DIV, 32'd100, 32'd7);
    issue(DIV, 32'hFFFF_FFFF, 32'd1);
    drain();
    issue(DIV, 32'd5, 32'd0);
    drain();

    // A second start mid-operation must not disturb the one in flight
    issue(MULT, 32'd3, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1;
    aluop = DIV;
    op1   = 32'd9;
    op2   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_mult", 64'(busy), 64'd1);
    drain();
    repeat (3) @(negedge clk);
    chk("idle_hold_r1", 64'(r1), 64'd9);

    start = 1'b1;
    aluop = 5'b00001;
    @(negedge clk);
    start = 1'b0;
    chk("bad_op_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);

    start = 1'b1;
    abort = 1'b1;
    aluop = MULT;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_idle_busy", 64'(busy), 64'd0);

    issue(MULT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (4) @(negedge clk);
    dropped = sb.pop_back();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_r1", 64'(r1), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_uf", 64'(uf), 64'd0);
    repeat (40) @(negedge clk);

    issue(DIV, 32'd1000, 32'd3);
    repeat (6) @(negedge clk);
    dropped = sb.pop_back();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_r1", 64'(r1), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_uf", 64'(uf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(MULT, 32'd2, 32'd2);
    drain();

    for (int i = 0; i < 40; i++) begin
      a = rnd_operand();
      b = rnd_operand();
      case ($urandom_range(0, 3))
        0, 1:    op = MULT;
        2:       op = DIV;
        default: begin op = DIV; b = '0; end
      endcase
      issue(op, a, b);
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
